// File: rtl/ram_port_b_arbiter.sv
// Round-robin arbiter and sequencer for sketch-counter RAM port B.
// Two valid/ready requesters share a multi-cycle RAM protocol, with range checking and an ack timeout.
module ram_port_b_arbiter #(
  parameter int AW      = 12,
  parameter int DW      = 4,
  parameter int DEPTH   = 2140,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [2*AW-1:0]   req_addr,
  input  logic [2*DW-1:0]   req_wdata,
  output logic [1:0]        resp_valid,
  output logic [DW-1:0]     resp_rdata,
  output logic              resp_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [AW-1:0]     ram_addr,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout,
  input  logic              ram_dout_valid
);

  localparam logic [AW:0] DEPTH_L   = (AW+1)'(DEPTH);
  localparam logic [3:0]  TIMEOUT_L = 4'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic            last_grant;  // also identifies the owner of the in-flight transaction
  logic [3:0]      cnt;
  logic [1:0]      grant;
  logic            win;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            sel_we;
  logic            in_range;

  always_comb begin
    grant = '0;
    if (state == IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

  assign req_ready = grant;
  assign win       = grant[1];
  assign sel_addr  = win ? req_addr[2*AW-1:AW]   : req_addr[AW-1:0];
  assign sel_wdata = win ? req_wdata[2*DW-1:DW]  : req_wdata[DW-1:0];
  assign sel_we    = win ? req_we[1] : req_we[0];
  assign in_range  = {1'b0, sel_addr} < DEPTH_L;

  // ram_we/ram_addr/ram_din double as the transaction latch and hold until RESP ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
    end else begin
      resp_valid <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      ram_en     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            last_grant <= win;
            if (!in_range) begin
              resp_valid <= win ? 2'b10 : 2'b01;
              resp_err   <= 1'b1;
              state      <= RESP;
            end else begin
              ram_en   <= 1'b1;
              ram_we   <= sel_we;
              ram_addr <= sel_addr;
              ram_din  <= sel_wdata;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (ram_dout_valid) begin
            resp_valid <= last_grant ? 2'b10 : 2'b01;
            resp_rdata <= ram_we ? '0 : ram_dout;
            state      <= RESP;
          end else if (cnt == TIMEOUT_L) begin
            resp_valid <= last_grant ? 2'b10 : 2'b01;
            resp_err   <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: begin
          ram_we   <= 1'b0;
          ram_addr <= '0;
          ram_din  <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_b_arbiter.sv
// Randomized and directed bench for ram_port_b_arbiter with a behavioural RAM
// and a transaction-level reference model of grants, timing and responses.
module tb_ram_port_b_arbiter;

  localparam int AW = 12;
  localparam int DW = 4;
  localparam int DEPTH = 2140;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_valid, req_ready, req_we, resp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0] resp_rdata, ram_din, ram_dout;
  logic resp_err, ram_en, ram_we, ram_dout_valid;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  ram_port_b_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_dout_valid(ram_dout_valid)
  );

  // RAM model: acknowledges three cycles after the enable pulse
  logic [3:0] mem [0:4095];
  logic mem_ready = 1'b0;
  logic [2:0] pipe;
  logic [3:0] junk = 4'h0;
  logic no_ack = 1'b0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) junk <= 4'($urandom);
  always @(posedge clk or posedge rst)
    if (rst) pipe <= '0;
    else     pipe <= {pipe[1:0], ram_en & ~no_ack};
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
      mem_ready <= 1'b1;
    end else if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_din;
    end
  end
  assign ram_dout_valid = pipe[2];
  assign ram_dout = pipe[2] ? mem[ram_addr] : junk;

  // reference model state
  logic [3:0] exp_mem [0:4095];
  int mdl_last, free_c, due_c, en_c, acc_c, exp_addr;
  bit rng, exp_we, exp_err;
  logic [1:0] own_oh;
  logic [3:0] exp_wd, exp_rd;
  int passed = 0, total = 0, accepts = 0, tie_stop = 1 << 30;
  bit one_shot = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic mdl_reset();
    mdl_last = 1; free_c = 0; due_c = -100; en_c = -100; acc_c = -100;
    rng = 1'b0; own_oh = '0;
  endtask

  task automatic set_req(input int r, input bit we, input int addr, input int wd);
    req_valid[r] = 1'b1;
    req_we[r] = we;
    req_addr[r*AW +: AW] = AW'(addr);
    req_wdata[r*DW +: DW] = DW'(wd);
  endtask

  task automatic step();
    int c, w;
    logic [1:0] v, exp_rdy;
    bit hold, accepted;
    @(negedge clk);
    c = cyc; v = req_valid; exp_rdy = '0; w = 0; accepted = 1'b0;
    if (c >= free_c && v != 2'b00) begin
      if (v == 2'b11) w = 1 - mdl_last;
      else w = v[1] ? 1 : 0;
      exp_rdy = 2'(1 << w);
    end
    chk("req_ready", req_ready, exp_rdy);
    chk("ram_en", ram_en, c == en_c);
    chk("resp_valid", resp_valid, (c == due_c) ? own_oh : 2'b00);
    if (c == due_c) begin
      chk("resp_rdata", resp_rdata, exp_rd);
      chk("resp_err", resp_err, exp_err);
    end
    hold = rng && c > acc_c && c <= due_c;
    chk("ram_addr", ram_addr, hold ? exp_addr : 0);
    chk("ram_we", ram_we, hold ? exp_we : 1'b0);
    chk("ram_din", ram_din, hold ? exp_wd : 4'h0);
    if (exp_rdy != 2'b00) begin
      accepted = 1'b1;
      acc_c = c;
      exp_addr = int'(req_addr[w*AW +: AW]);
      exp_we = req_we[w];
      exp_wd = req_wdata[w*DW +: DW];
      own_oh = exp_rdy;
      mdl_last = w;
      rng = exp_addr < DEPTH;
      if (rng) begin
        en_c = c + 1;
        due_c = no_ack ? c + 3 + TO : c + 5;
        exp_err = no_ack;
        exp_rd = (no_ack || exp_we) ? 4'h0 : exp_mem[exp_addr];
        if (exp_we) exp_mem[exp_addr] = exp_wd;
      end else begin
        en_c = -100;
        due_c = c + 1;
        exp_err = 1'b1;
        exp_rd = 4'h0;
      end
      free_c = due_c + 1;
    end
    @(posedge clk); #1;
    if (accepted) begin
      accepts++;
      if (one_shot) begin
        // scramble the fields the arbiter must no longer depend on
        req_valid[w] = 1'b0;
        req_addr[w*AW +: AW] = AW'($urandom);
        req_we[w] = 1'($urandom);
        req_wdata[w*DW +: DW] = DW'($urandom);
      end
      if (accepts >= tie_stop) req_valid = '0;
    end
  endtask

  task automatic drain(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (req_valid == 2'b00 && cyc >= free_c) begin
        done = 1'b1;
        break;
      end
      step();
    end
    if (!done) done = (req_valid == 2'b00 && cyc >= free_c);
    chk("drain_done", done, 1'b1);
  endtask

  function automatic int pick_addr();
    int k = $urandom_range(0, 9);
    if (k == 0) return $urandom_range(DEPTH, 4095);
    if (k == 1) return DEPTH - 1;
    return $urandom_range(0, 15);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_ram_en"}, ram_en, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_din"}, ram_din, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed hang, expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0] pat;
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 4096; i++) exp_mem[i] = '0;
    mdl_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // write then read back across requesters
    set_req(0, 1'b1, 12'h005, 4'hA); drain(40);
    set_req(1, 1'b0, 12'h005, 0);    drain(40);

    // continuous tie: grants alternate, one per six cycles
    tie_stop = accepts + 4; one_shot = 1'b0;
    set_req(0, 1'b0, 12'h010, 0);
    set_req(1, 1'b0, 12'h020, 0);
    drain(60);
    one_shot = 1'b1; tie_stop = 1 << 30;

    // out-of-range boundary
    set_req(0, 1'b0, DEPTH, 0); drain(20);

    // missing acknowledge, then a normal transaction
    no_ack = 1'b1;
    set_req(1, 1'b0, 12'h123, 0); drain(40);
    no_ack = 1'b0;
    set_req(0, 1'b0, 12'h005, 0); drain(20);

    // address hold while the request bus changes
    set_req(0, 1'b1, 12'h7FF, 4'h3); drain(20);
    set_req(1, 1'b0, 12'h7FF, 0);    drain(20);

    for (int it = 0; it < 40; it++) begin
      pat = 2'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++)
        if (pat[r]) set_req(r, 1'($urandom_range(0, 1)), pick_addr(), $urandom_range(0, 15));
      drain(60);
    end

    // reset in WAIT, then a tie must go to requester 0
    set_req(1, 1'b0, 12'h005, 0);
    repeat (3) step();
    #3 rst = 1'b1;
    #1 chk_all_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    @(posedge clk); #1;
    set_req(0, 1'b0, 12'h010, 0);
    set_req(1, 1'b0, 12'h020, 0);
    drain(40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
